// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the register-file scoreboard.
package cpu_pkg;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  localparam int CNT_W    = 2;

  typedef enum logic [1:0] {
    SB_RUN,
    SB_DRAIN,
    SB_HALTED
  } sb_state_e;
endpackage

// File: rtl/sb_counter.sv
// In-flight writer counter: one increment, two decrements per cycle.
// Saturates at the top and clamps at zero, flagging an underflow
// whenever more retires arrive than there are writers in flight.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec_a,
  input  logic             i_dec_b,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_underflow
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W+1:0] w_sum;
  logic [CNT_W-1:0] w_next;

  // Two extra bits: top bit is the sign (underflow), next flags overflow.
  always_comb begin
    w_sum = {2'b00, r_cnt}
          + {{(CNT_W+1){1'b0}}, i_inc}
          - {{(CNT_W+1){1'b0}}, i_dec_a}
          - {{(CNT_W+1){1'b0}}, i_dec_b};
    o_underflow = w_sum[CNT_W+1];
    if (w_sum[CNT_W+1])  w_next = '0;
    else if (w_sum[CNT_W]) w_next = CNT_MAX;
    else                 w_next = w_sum[CNT_W-1:0];
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= w_next;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/regfile_scoreboard.sv
// Issue-side hazard scoreboard for the register file and PS flag.
// One sb_counter per register plus one for PS tracks in-flight writers;
// RAW hazards and full counters stall issue, and a drain FSM quiesces
// the pipeline for halt/interrupt.
// Optional feature macro: SCOREBOARD_WB_BYPASS_EN adds writeback bypass
// (a source whose last writer retires via wb this cycle does not stall)
// and the byp_ra / byp_rt / byp_ps outputs.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = cpu_pkg::NUM_REGS,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int CNT_W    = cpu_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iss_valid,
  input  logic                iss_use_ra,
  input  logic                iss_use_rt,
  input  logic [ADDR_W-1:0]   iss_rt_addr,
  input  logic                iss_read_ps,
  input  logic                iss_reg_write,
  input  logic [ADDR_W-1:0]   iss_reg_addr,
  input  logic                iss_ps_write,
  input  logic                pipe_hold,
  output logic                iss_stall,
  input  logic                wb_valid,
  input  logic                wb_reg_write,
  input  logic [ADDR_W-1:0]   wb_reg_addr,
  input  logic                wb_ps_write,
  input  logic                kill_valid,
  input  logic                kill_reg_write,
  input  logic [ADDR_W-1:0]   kill_reg_addr,
  input  logic                kill_ps_write,
  input  logic                drain_req,
  output logic                drained,
  output logic [NUM_REGS-1:0] busy_regs,
  output logic                ps_busy,
`ifdef SCOREBOARD_WB_BYPASS_EN
  output logic                byp_ra,
  output logic                byp_rt,
  output logic                byp_ps,
`endif
  output logic                sb_err
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Index NUM_REGS is the PS flag counter.
  logic [NUM_REGS:0][CNT_W-1:0] w_cnt;
  logic [NUM_REGS:0]            w_busy;
  logic [NUM_REGS:0]            w_uflow;
  logic                         w_fire;
  logic                         w_ra_haz, w_rt_haz, w_ps_haz, w_full;
  logic                         w_all_idle;
  sb_state_e                    r_state, w_next_state;
  logic                         r_sb_err;

  assign w_fire = iss_valid & ~iss_stall & ~pipe_hold;

  for (genvar g = 0; g <= NUM_REGS; g++) begin : g_cnt
    logic w_inc, w_da, w_db;
    if (g < NUM_REGS) begin : g_reg
      assign w_inc = w_fire & iss_reg_write & (iss_reg_addr == ADDR_W'(g));
      assign w_da  = wb_valid & wb_reg_write & (wb_reg_addr == ADDR_W'(g));
      assign w_db  = kill_valid & kill_reg_write & (kill_reg_addr == ADDR_W'(g));
    end else begin : g_ps
      assign w_inc = w_fire & iss_ps_write;
      assign w_da  = wb_valid & wb_ps_write;
      assign w_db  = kill_valid & kill_ps_write;
    end
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .i_inc       (w_inc),
      .i_dec_a     (w_da),
      .i_dec_b     (w_db),
      .o_cnt       (w_cnt[g]),
      .o_underflow (w_uflow[g])
    );
    assign w_busy[g] = |w_cnt[g];
  end

  assign busy_regs  = w_busy[NUM_REGS-1:0];
  assign ps_busy    = w_busy[NUM_REGS];
  assign w_all_idle = ~|w_busy;

`ifdef SCOREBOARD_WB_BYPASS_EN
  // Last in-flight writer retiring via wb this cycle: forward wb data instead of stalling.
  logic w_hit_ra, w_hit_rt, w_hit_ps;
  assign w_hit_ra = wb_valid & wb_reg_write & (wb_reg_addr == '0)
                  & (w_cnt[0] == CNT_W'(1));
  assign w_hit_rt = wb_valid & wb_reg_write & (wb_reg_addr == iss_rt_addr)
                  & (w_cnt[iss_rt_addr] == CNT_W'(1));
  assign w_hit_ps = wb_valid & wb_ps_write & (w_cnt[NUM_REGS] == CNT_W'(1));
  assign byp_ra   = iss_valid & iss_use_ra  & w_hit_ra;
  assign byp_rt   = iss_valid & iss_use_rt  & w_hit_rt;
  assign byp_ps   = iss_valid & iss_read_ps & w_hit_ps;
`endif

  // Issue stall from current counts and FSM state; pipe_hold deliberately excluded.
  always_comb begin
    w_ra_haz = w_busy[0];
    w_rt_haz = w_busy[iss_rt_addr];
    w_ps_haz = w_busy[NUM_REGS];
`ifdef SCOREBOARD_WB_BYPASS_EN
    w_ra_haz = w_ra_haz & ~w_hit_ra;
    w_rt_haz = w_rt_haz & ~w_hit_rt;
    w_ps_haz = w_ps_haz & ~w_hit_ps;
`endif
    w_full = (iss_reg_write & (w_cnt[iss_reg_addr] == CNT_MAX))
           | (iss_ps_write  & (w_cnt[NUM_REGS]   == CNT_MAX));
    iss_stall = iss_valid & ((r_state != SB_RUN)
                             | (iss_use_ra  & w_ra_haz)
                             | (iss_use_rt  & w_rt_haz)
                             | (iss_read_ps & w_ps_haz)
                             | w_full);
  end

  // Drain FSM next state; dropping the request always returns to RUN.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      SB_RUN:    if (drain_req) w_next_state = SB_DRAIN;
      SB_DRAIN:  if (!drain_req) w_next_state = SB_RUN;
                 else if (w_all_idle) w_next_state = SB_HALTED;
      SB_HALTED: if (!drain_req) w_next_state = SB_RUN;
      default:   w_next_state = SB_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= SB_RUN;
    else     r_state <= w_next_state;
  end

  // Sticky error on any counter underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sb_err <= 1'b0;
    else     r_sb_err <= r_sb_err | (|w_uflow);
  end

  assign drained = (r_state == SB_HALTED);
  assign sb_err  = r_sb_err;
endmodule
